// File: rtl/dec_bit_packer.sv
// rtl/dec_bit_packer.sv - packs non-frozen decoded bits LSB-first and writes the word to DEC memory
module dec_bit_packer #(
    parameter int MAX_K  = 140,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_start,
    input  logic [ADDR_W-1:0] pkt_idx,
    input  logic [7:0]        k_num,
    input  logic [9:0]        n_num,
    input  logic              bit_valid,
    input  logic              bit_val,
    input  logic              bit_frozen,
    output logic              bit_ready,
    output logic              wen,
    output logic [ADDR_W-1:0] waddr,
    output logic [MAX_K-1:0]  wdata,
    output logic              pkt_done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_REJECT  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] idx_q;
    logic [7:0]        k_q;
    logic [9:0]        n_q;
    logic [MAX_K-1:0]  pack_buf;
    logic [9:0]        pos_cnt;
    logic [7:0]        info_cnt;

    logic              n_legal;
    logic              k_legal;
    logic              params_ok;
    logic              accept;
    logic              last_pos;
    logic              info_room;

    assign n_legal   = (n_num == 10'd128) || (n_num == 10'd256) || (n_num == 10'd512);
    assign k_legal   = (k_num != 8'd0) && (int'(k_num) <= MAX_K);
    assign params_ok = n_legal && k_legal;

    assign bit_ready = (state == S_COLLECT);
    assign accept    = bit_valid && bit_ready;
    assign last_pos  = (pos_cnt == (n_q - 10'd1));
    assign info_room = (info_cnt < k_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pkt_start) begin
                    state_nxt = params_ok ? S_COLLECT : S_REJECT;
                end
            end
            S_COLLECT: begin
                if (accept && last_pos) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE:  state_nxt = S_IDLE;
            S_REJECT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Strobes default low so wen/pkt_done are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            k_q      <= '0;
            n_q      <= '0;
            pack_buf <= '0;
            pos_cnt  <= '0;
            info_cnt <= '0;
            err      <= 1'b0;
            wen      <= 1'b0;
            pkt_done <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
        end else begin
            wen      <= 1'b0;
            pkt_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pkt_start) begin
                        idx_q    <= pkt_idx;
                        k_q      <= k_num;
                        n_q      <= n_num;
                        pack_buf <= '0;
                        pos_cnt  <= '0;
                        info_cnt <= '0;
                        err      <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        pos_cnt <= pos_cnt + 10'd1;
                        if (!bit_frozen) begin
                            // Surplus info bits are dropped; buffer above K stays zero.
                            if (info_room) begin
                                pack_buf[info_cnt] <= bit_val;
                                info_cnt           <= info_cnt + 8'd1;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    wen      <= 1'b1;
                    pkt_done <= 1'b1;
                    waddr    <= idx_q;
                    wdata    <= pack_buf;
                    if (info_cnt != k_q) begin
                        err <= 1'b1;
                    end
                end
                S_REJECT: begin
                    pkt_done <= 1'b1;
                    err      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_bit_packer.sv
// tb/tb_dec_bit_packer.sv - randomized self-checking bench for dec_bit_packer
module tb_dec_bit_packer;

    logic         clk = 1'b0;
    logic         rst;
    logic         pkt_start;
    logic [5:0]   pkt_idx;
    logic [7:0]   k_num;
    logic [9:0]   n_num;
    logic         bit_valid;
    logic         bit_val;
    logic         bit_frozen;
    logic         bit_ready;
    logic         wen;
    logic [5:0]   waddr;
    logic [139:0] wdata;
    logic         pkt_done;
    logic         err;

    int tests_run    = 0;
    int tests_failed = 0;
    int wen_total    = 0;

    bit frz_q[$];
    bit val_q[$];

    logic         o_timeout, o_early_wen, o_ready_after, o_err_pre;
    logic         o_wen, o_done, o_err, o_late;
    logic [5:0]   o_waddr;
    logic [139:0] o_wdata;

    logic [139:0] exp_w;
    logic         exp_e, exp_pre;
    logic [5:0]   hold_addr;
    logic [139:0] hold_data;

    dec_bit_packer #(.MAX_K(140), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .pkt_start(pkt_start), .pkt_idx(pkt_idx),
        .k_num(k_num), .n_num(n_num), .bit_valid(bit_valid), .bit_val(bit_val),
        .bit_frozen(bit_frozen), .bit_ready(bit_ready), .wen(wen), .waddr(waddr),
        .wdata(wdata), .pkt_done(pkt_done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wen === 1'b1) wen_total++;

    // Reference: info bits in stream order, first K packed from bit 0.
    function automatic void model(input int k);
        int cnt = 0;
        exp_w = '0;
        foreach (frz_q[i]) begin
            if (!frz_q[i]) begin
                if (cnt < k) exp_w[cnt] = val_q[i];
                cnt++;
            end
        end
        exp_pre = (cnt > k);
        exp_e   = (cnt != k);
    endfunction

    task automatic build_random(input int n, input int m);
        frz_q.delete(); val_q.delete();
        for (int i = 0; i < n; i++) begin
            frz_q.push_back(i >= m);
            val_q.push_back(1'($urandom));
        end
        for (int i = n - 1; i > 0; i--) begin
            int j = $urandom_range(i);
            bit t = frz_q[i];
            frz_q[i] = frz_q[j];
            frz_q[j] = t;
        end
    endtask

    task automatic drive_packet(input int idx, input int k, input int n, input int duty, input int mid_start);
        int  i = 0, cyc = 0;
        bit  acc;
        @(negedge clk);
        pkt_start = 1; pkt_idx = 6'(idx); k_num = 8'(k); n_num = 10'(n);
        bit_valid = 1; bit_val = 1; bit_frozen = 0;
        @(negedge clk);
        pkt_start = 0;
        o_timeout = 0;
        while (i < n) begin
            if (cyc > 20000) begin o_timeout = 1; break; end
            bit_valid  = ($urandom_range(99) < duty);
            bit_val    = val_q[i];
            bit_frozen = frz_q[i];
            if (i == mid_start && pkt_start == 0 && cyc > 0) begin
                pkt_start = 1; pkt_idx = 6'(idx) ^ 6'd1; k_num = 8'd3; n_num = 10'd256;
            end else begin
                pkt_start = 0;
            end
            #1 acc = bit_valid && bit_ready;
            @(negedge clk);
            if (acc) i++;
            cyc++;
        end
        bit_valid = 0; pkt_start = 0;
        o_early_wen = wen; o_ready_after = bit_ready; o_err_pre = err;
        @(negedge clk);
        o_wen = wen; o_done = pkt_done; o_waddr = waddr; o_wdata = wdata; o_err = err;
        @(negedge clk);
        o_late = wen | pkt_done;
    endtask

    task automatic test_reset;
        rst = 1; pkt_start = 0; pkt_idx = 0; k_num = 0; n_num = 0;
        bit_valid = 0; bit_val = 0; bit_frozen = 0;
        repeat (3) @(negedge clk);
        tests_run++; if ({bit_ready, wen, pkt_done, err} !== 4'b0) begin tests_failed++; $display("FAIL reset_flags got %b exp 0000", {bit_ready, wen, pkt_done, err}); end
        tests_run++; if (waddr !== 6'd0 || wdata !== 140'd0) begin tests_failed++; $display("FAIL reset_data got %h/%h exp 0/0", waddr, wdata); end
        rst = 0;
        hold_addr = 0; hold_data = 0;
    endtask

    task automatic test_t1;
        logic [139:0] c1 = 140'h4D;
        bit info [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
        frz_q.delete(); val_q.delete();
        for (int i = 0; i < 128; i++) begin
            frz_q.push_back(i < 120);
            val_q.push_back(i < 120 ? 1'($urandom) : info[i - 120]);
        end
        drive_packet(3, 8, 128, 100, -1);
        tests_run++; if (o_timeout !== 1'b0) begin tests_failed++; $display("FAIL t1_timeout got %b exp 0", o_timeout); end
        tests_run++; if (o_early_wen !== 1'b0 || o_ready_after !== 1'b0) begin tests_failed++; $display("FAIL t1_latency_early got wen=%b ready=%b exp 0 0", o_early_wen, o_ready_after); end
        tests_run++; if (o_wen !== 1'b1 || o_done !== 1'b1) begin tests_failed++; $display("FAIL t1_strobe got wen=%b done=%b exp 1 1", o_wen, o_done); end
        tests_run++; if (o_waddr !== 6'd3) begin tests_failed++; $display("FAIL t1_waddr got %0d exp 3", o_waddr); end
        tests_run++; if (o_wdata !== c1) begin tests_failed++; $display("FAIL t1_wdata got %h exp %h", o_wdata, c1); end
        tests_run++; if (o_err !== 1'b0 || o_late !== 1'b0) begin tests_failed++; $display("FAIL t1_err_late got err=%b late=%b exp 0 0", o_err, o_late); end
        hold_addr = 3; hold_data = c1;
    endtask

    task automatic test_t2;
        logic [139:0] c2 = {70{2'b01}};
        frz_q.delete(); val_q.delete();
        for (int i = 0; i < 512; i++) begin
            frz_q.push_back(i < 372);
            val_q.push_back(i < 372 ? 1'($urandom) : 1'(((i - 372) % 2) == 0));
        end
        drive_packet(17, 140, 512, 100, -1);
        tests_run++; if (o_wdata !== c2 || o_waddr !== 6'd17) begin tests_failed++; $display("FAIL t2_wdata got %h@%0d exp %h@17", o_wdata, o_waddr, c2); end
        tests_run++; if (o_done !== 1'b1 || o_late !== 1'b0 || o_early_wen !== 1'b0) begin tests_failed++; $display("FAIL t2_done_pulse got %b%b%b exp 100", o_done, o_late, o_early_wen); end
        tests_run++; if (o_err !== 1'b0) begin tests_failed++; $display("FAIL t2_err got %b exp 0", o_err); end
        hold_addr = 17; hold_data = c2;
    endtask

    task automatic test_t3;
        build_random(256, 6);
        model(4);
        drive_packet(40, 4, 256, 100, -1);
        tests_run++; if (o_wen !== 1'b1 || o_wdata !== exp_w) begin tests_failed++; $display("FAIL t3_write got wen=%b %h exp 1 %h", o_wen, o_wdata, exp_w); end
        tests_run++; if (o_err_pre !== exp_pre || o_err !== 1'b1) begin tests_failed++; $display("FAIL t3_err got pre=%b fin=%b exp %b 1", o_err_pre, o_err, exp_pre); end
        hold_addr = 40; hold_data = exp_w;
    endtask

    task automatic test_t4_reject;
        int nb [3] = '{200, 128, 128};
        int kb [3] = '{8, 0, 141};
        for (int c = 0; c < 3; c++) begin
            int wb = wen_total;
            @(negedge clk);
            pkt_start = 1; pkt_idx = 6'd9; k_num = 8'(kb[c]); n_num = 10'(nb[c]); bit_valid = 1;
            @(negedge clk);
            pkt_start = 0;
            tests_run++; if (bit_ready !== 1'b0 || pkt_done !== 1'b0) begin tests_failed++; $display("FAIL t4_rej_cycle%0d got ready=%b done=%b exp 0 0", c, bit_ready, pkt_done); end
            @(negedge clk);
            tests_run++; if (pkt_done !== 1'b1 || err !== 1'b1 || wen !== 1'b0) begin tests_failed++; $display("FAIL t4_rej_flags%0d got done=%b err=%b wen=%b exp 1 1 0", c, pkt_done, err, wen); end
            tests_run++; if (waddr !== hold_addr || wdata !== hold_data) begin tests_failed++; $display("FAIL t4_rej_hold%0d got %0d %h exp %0d %h", c, waddr, wdata, hold_addr, hold_data); end
            @(negedge clk);
            bit_valid = 0;
            tests_run++; if (pkt_done !== 1'b0 || err !== 1'b1 || wen_total != wb) begin tests_failed++; $display("FAIL t4_rej_after%0d got done=%b err=%b wens=%0d exp 0 1 %0d", c, pkt_done, err, wen_total, wb); end
        end
    endtask

    task automatic test_t5_duty;
        build_random(128, 16);
        model(16);
        drive_packet(21, 16, 128, 100, -1);
        tests_run++; if (o_wdata !== exp_w || o_err !== 1'b0) begin tests_failed++; $display("FAIL t5_full_rate got %h err=%b exp %h 0", o_wdata, o_err, exp_w); end
        drive_packet(22, 16, 128, 30, -1);
        tests_run++; if (o_timeout !== 1'b0 || o_wdata !== exp_w || o_waddr !== 6'd22) begin tests_failed++; $display("FAIL t5_duty30 got %h@%0d exp %h@22", o_wdata, o_waddr, exp_w); end
        tests_run++; if (o_err !== 1'b0 || o_wen !== 1'b1 || o_late !== 1'b0) begin tests_failed++; $display("FAIL t5_duty30_flags got err=%b wen=%b late=%b exp 0 1 0", o_err, o_wen, o_late); end
        hold_addr = 22; hold_data = exp_w;
    endtask

    task automatic test_t6_reset_mid;
        int wb;
        @(negedge clk);
        pkt_start = 1; pkt_idx = 6'd50; k_num = 8'd8; n_num = 10'd128;
        @(negedge clk);
        pkt_start = 0;
        for (int i = 0; i < 60; i++) begin
            bit_valid = 1; bit_val = 1'($urandom); bit_frozen = 0;
            @(negedge clk);
        end
        tests_run++; if (bit_ready !== 1'b1 || err !== 1'b1) begin tests_failed++; $display("FAIL t6_pre_reset got ready=%b err=%b exp 1 1", bit_ready, err); end
        wb = wen_total;
        rst = 1; bit_valid = 0;
        @(negedge clk);
        rst = 0;
        tests_run++; if ({bit_ready, wen, pkt_done, err} !== 4'b0 || waddr !== 6'd0 || wdata !== 140'd0) begin tests_failed++; $display("FAIL t6_reset_outs got %b %0d %h exp 0000 0 0", {bit_ready, wen, pkt_done, err}, waddr, wdata); end
        repeat (3) @(negedge clk);
        tests_run++; if (wen_total != wb || pkt_done !== 1'b0) begin tests_failed++; $display("FAIL t6_no_write got wens=%0d done=%b exp %0d 0", wen_total, pkt_done, wb); end
        build_random(128, 8);
        model(8);
        drive_packet(12, 8, 128, 100, 30);
        tests_run++; if (o_wdata !== exp_w || o_waddr !== 6'd12) begin tests_failed++; $display("FAIL t6_after got %h@%0d exp %h@12", o_wdata, o_waddr, exp_w); end
        tests_run++; if (o_err !== 1'b0 || o_wen !== 1'b1) begin tests_failed++; $display("FAIL t6_after_flags got err=%b wen=%b exp 0 1", o_err, o_wen); end
        hold_addr = 12; hold_data = exp_w;
    endtask

    task automatic test_random;
        int ns [3] = '{128, 256, 512};
        for (int p = 0; p < 6; p++) begin
            int n = ns[$urandom_range(2)];
            int k = $urandom_range(1, 140);
            int m = k;
            int r = $urandom_range(3);
            int idx = $urandom_range(63);
            if (r == 0) m = k + 1;
            if (r == 1) m = k - 1;
            build_random(n, m);
            model(k);
            drive_packet(idx, k, n, $urandom_range(30, 100), -1);
            tests_run++; if (o_timeout !== 1'b0 || o_wen !== 1'b1 || o_waddr !== 6'(idx)) begin tests_failed++; $display("FAIL rnd%0d_write got wen=%b @%0d exp 1 @%0d", p, o_wen, o_waddr, idx); end
            tests_run++; if (o_wdata !== exp_w) begin tests_failed++; $display("FAIL rnd%0d_wdata got %h exp %h", p, o_wdata, exp_w); end
            tests_run++; if (o_err !== exp_e || o_err_pre !== exp_pre) begin tests_failed++; $display("FAIL rnd%0d_err got %b/%b exp %b/%b", p, o_err_pre, o_err, exp_pre, exp_e); end
        end
    endtask

    initial begin
        test_reset();
        test_t1();
        test_t2();
        test_t3();
        test_t4_reject();
        test_t5_duty();
        test_t6_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
